// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

  // Why the pipeline is stalled this cycle. Earlier causes in this list take priority.
  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LOAD_USE = 3'd1,
    CAUSE_BR_EX    = 3'd2,
    CAUSE_LOAD_MEM = 3'd3,
    CAUSE_MDU      = 3'd4
  } stallCause_t;

  // States of the mult/div unit occupancy timer.
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mduState_t;

  localparam int MDU_LATENCY_DEFAULT = 32;
  localparam int MDU_CNT_W           = 6;

  // A register r is a hazard when it is nonzero and is a source that the ID instruction actually reads.
  function automatic logic srcMatch(input logic [4:0] r,
                                    input logic [4:0] rs, input logic usesRs,
                                    input logic [4:0] rt, input logic usesRt);
    return (r != 5'd0) && ((usesRs && (r == rs)) || (usesRt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_timer.sv
// Tracks how long the mult/div unit holds HI/LO after an op leaves ID/EX.
module mdu_busy_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mduStart,
  output logic mduBusy
);

  mduState_t             state, stateNext;
  logic [MDU_CNT_W-1:0]  cnt, cntNext;

  // State and countdown registers; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state: load LATENCY-1 on start, count down while busy, return to idle as cnt reaches 0.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      MDU_IDLE: begin
        if (mduStart) begin
          stateNext = MDU_BUSY;
          cntNext   = MDU_CNT_W'(MDU_LATENCY - 1);
        end
      end
      MDU_BUSY: begin
        cntNext = cnt - 1'b1;
        if (cnt == MDU_CNT_W'(1)) begin
          stateNext = MDU_IDLE;
        end
      end
      default: begin
        stateNext = MDU_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign mduBusy = (state == MDU_BUSY);

  // A second start while busy is ignored by the logic; the ID-stage hold should make it impossible.
  startWhileBusy: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(state == MDU_BUSY && mduStart));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Detects hazards that forwarding cannot cover and drives PC/IF-ID enables, flushes and a stall counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_inIFID,
  input  logic [4:0]       rt_inIFID,
  input  logic             uses_rs_inIFID,
  input  logic             uses_rt_inIFID,
  input  logic             branch_inIFID,
  input  logic             mdu_use_inIFID,
  input  logic             take_branch,
  input  logic             MemRead_inIDEX,
  input  logic             RegWrite_inIDEX,
  input  logic [4:0]       rd_Or_rt_inIDEX,
  input  logic             MemRead_inEXMEM,
  input  logic [4:0]       rd_Or_rt_inEXMEM,
  input  logic             mdu_start_inIDEX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXFlush,
  output logic             IFIDFlush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic        matchEx, matchMem;
  logic        loadUse, brEx, loadMem, mduHold;
  logic        stall;
  stallCause_t stallCause;

  mdu_busy_timer #(.MDU_LATENCY(MDU_LATENCY)) uMduTimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .mduStart (mdu_start_inIDEX),
    .mduBusy  (mdu_busy)
  );

  assign matchEx  = srcMatch(rd_Or_rt_inIDEX,  rs_inIFID, uses_rs_inIFID, rt_inIFID, uses_rt_inIFID);
  assign matchMem = srcMatch(rd_Or_rt_inEXMEM, rs_inIFID, uses_rs_inIFID, rt_inIFID, uses_rt_inIFID);

  assign loadUse = MemRead_inIDEX && matchEx;
  assign brEx    = branch_inIFID && RegWrite_inIDEX && matchEx;
  assign loadMem = branch_inIFID && MemRead_inEXMEM && matchMem;
  assign mduHold = mdu_use_inIFID && mdu_busy;

  // Classify the stall by its highest-priority cause; any cause at all stalls the front end.
  always_comb begin
    stallCause = CAUSE_NONE;
    if (loadUse)      stallCause = CAUSE_LOAD_USE;
    else if (brEx)    stallCause = CAUSE_BR_EX;
    else if (loadMem) stallCause = CAUSE_LOAD_MEM;
    else if (mduHold) stallCause = CAUSE_MDU;
  end

  assign stall = (stallCause != CAUSE_NONE);

  // Front-end controls: a stall freezes PC/IF-ID and bubbles EX, and overrides a taken branch whose operands are stale.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IDEXFlush = 1'b0;
    IFIDFlush = 1'b0;
    if (stall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end else if (take_branch) begin
      IFIDFlush = 1'b1;
    end
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven checks of the hazard/stall controller plus multi-cycle sequences.
module tb_hazard_stall_ctrl;

  localparam int LAT   = 4;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       branch;
    logic       mduUse;
    logic       takeBranch;
    logic       memReadEx;
    logic       regWriteEx;
    logic [4:0] rdEx;
    logic       memReadMem;
    logic [4:0] rdMem;
    logic       mduStart;
  } inVec_t;

  // exp bits: {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush}
  typedef struct {
    string      name;
    inVec_t     in;
    logic [3:0] exp;
  } vec_t;

  logic          clk, rst_n;
  inVec_t        cur;
  logic          PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, mdu_busy;
  logic [CW-1:0] stall_cycles;

  int checks, failures, expCnt;
  vec_t vecs[12];

  hazard_stall_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rs_inIFID        (cur.rs),
    .rt_inIFID        (cur.rt),
    .uses_rs_inIFID   (cur.usesRs),
    .uses_rt_inIFID   (cur.usesRt),
    .branch_inIFID    (cur.branch),
    .mdu_use_inIFID   (cur.mduUse),
    .take_branch      (cur.takeBranch),
    .MemRead_inIDEX   (cur.memReadEx),
    .RegWrite_inIDEX  (cur.regWriteEx),
    .rd_Or_rt_inIDEX  (cur.rdEx),
    .MemRead_inEXMEM  (cur.memReadMem),
    .rd_Or_rt_inEXMEM (cur.rdMem),
    .mdu_start_inIDEX (cur.mduStart),
    .PCWrite          (PCWrite),
    .IFIDWrite        (IFIDWrite),
    .IDEXFlush        (IDEXFlush),
    .IFIDFlush        (IFIDFlush),
    .mdu_busy         (mdu_busy),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input inVec_t v);
    cur = v;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: ctrl {PCW,IFIDW,IDEXF,IFIDF} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance expected counter when the current cycle is expected to stall.
  task automatic countStall(input logic [3:0] exp);
    if (exp[1] && expCnt < CMAX) expCnt++;
  endtask

  initial begin
    checks = 0; failures = 0; expCnt = 0;
    cur = '0;
    rst_n = 1'b0;

    vecs[0]  = '{name:"idle",          in:'{default:'0}, exp:4'b1100};
    vecs[1]  = '{name:"loadUseRs",     in:'{rs:5'd2, usesRs:1'b1, memReadEx:1'b1, rdEx:5'd2, default:'0}, exp:4'b0010};
    vecs[2]  = '{name:"loadUseRt",     in:'{rt:5'd7, usesRt:1'b1, memReadEx:1'b1, rdEx:5'd7, default:'0}, exp:4'b0010};
    vecs[3]  = '{name:"rtNotUsed",     in:'{rt:5'd7, memReadEx:1'b1, rdEx:5'd7, default:'0}, exp:4'b1100};
    vecs[4]  = '{name:"reg0NoHazard",  in:'{usesRs:1'b1, usesRt:1'b1, memReadEx:1'b1, default:'0}, exp:4'b1100};
    vecs[5]  = '{name:"brExTakeIgn",   in:'{rs:5'd9, usesRs:1'b1, branch:1'b1, takeBranch:1'b1, regWriteEx:1'b1, rdEx:5'd9, default:'0}, exp:4'b0010};
    vecs[6]  = '{name:"brNoRegWrite",  in:'{rs:5'd9, usesRs:1'b1, branch:1'b1, takeBranch:1'b1, rdEx:5'd9, default:'0}, exp:4'b1101};
    vecs[7]  = '{name:"loadMemBr",     in:'{rt:5'd4, usesRt:1'b1, branch:1'b1, memReadMem:1'b1, rdMem:5'd4, default:'0}, exp:4'b0010};
    vecs[8]  = '{name:"loadMemNoBr",   in:'{rt:5'd4, usesRt:1'b1, memReadMem:1'b1, rdMem:5'd4, default:'0}, exp:4'b1100};
    vecs[9]  = '{name:"takeBranch",    in:'{takeBranch:1'b1, default:'0}, exp:4'b1101};
    vecs[10] = '{name:"aluNoBranch",   in:'{rs:5'd3, usesRs:1'b1, regWriteEx:1'b1, rdEx:5'd3, default:'0}, exp:4'b1100};
    vecs[11] = '{name:"mduUseIdle",    in:'{mduUse:1'b1, default:'0}, exp:4'b1100};

    // Reset state
    #12;
    checkVal("resetBusy", int'(mdu_busy), 0);
    checkVal("resetCnt", int'(stall_cycles), 0);
    checkOutput("resetCtrl", 4'b1100);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle decode
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].in);
      #1;
      checkOutput(vecs[i].name, vecs[i].exp);
      checkVal({vecs[i].name, "_cnt"}, int'(stall_cycles), expCnt);
      countStall(vecs[i].exp);
    end

    // lw $5 then beq $5: two stall cycles, then the taken branch flushes
    @(negedge clk);
    applyStimulus('{rs:5'd5, usesRs:1'b1, branch:1'b1, takeBranch:1'b1, memReadEx:1'b1, regWriteEx:1'b1, rdEx:5'd5, default:'0});
    #1; checkOutput("lwBeqCyc1", 4'b0010); countStall(4'b0010);
    @(negedge clk);
    applyStimulus('{rs:5'd5, usesRs:1'b1, branch:1'b1, takeBranch:1'b1, memReadMem:1'b1, rdMem:5'd5, default:'0});
    #1; checkOutput("lwBeqCyc2", 4'b0010); countStall(4'b0010);
    @(negedge clk);
    applyStimulus('{rs:5'd5, usesRs:1'b1, branch:1'b1, takeBranch:1'b1, default:'0});
    #1; checkOutput("lwBeqCyc3", 4'b1101);
    checkVal("lwBeqCnt", int'(stall_cycles), expCnt);

    // MDU op: busy for LAT-1 cycles, mfhi in ID stalls exactly then
    @(negedge clk);
    applyStimulus('{mduStart:1'b1, default:'0});
    #1; checkVal("mduNotYetBusy", int'(mdu_busy), 0);
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      applyStimulus('{mduUse:1'b1, default:'0});
      #1;
      checkVal($sformatf("mduBusy%0d", i), int'(mdu_busy), 1);
      checkOutput($sformatf("mfhiHold%0d", i), 4'b0010);
      countStall(4'b0010);
    end
    @(negedge clk);
    #1;
    checkVal("mduDone", int'(mdu_busy), 0);
    checkOutput("mfhiIssue", 4'b1100);
    checkVal("mduCnt", int'(stall_cycles), expCnt);

    // Async reset in the middle of an MDU op (cnt==2)
    @(negedge clk);
    applyStimulus('{mduStart:1'b1, default:'0});
    @(negedge clk);
    applyStimulus('{mduUse:1'b1, default:'0});
    @(negedge clk);
    #1; checkVal("midOpBusy", int'(mdu_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("asyncRstBusy", int'(mdu_busy), 0);
    checkVal("asyncRstCnt", int'(stall_cycles), 0);
    checkOutput("asyncRstCtrl", 4'b1100);
    expCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkVal("postRstBusy", int'(mdu_busy), 0);
    checkOutput("mfloIssue", 4'b1100);
    checkVal("postRstCnt", int'(stall_cycles), 0);

    // Saturation: hold a load-use stall for 2^CW+5 cycles
    applyStimulus('{rs:5'd2, usesRs:1'b1, memReadEx:1'b1, rdEx:5'd2, default:'0});
    for (int i = 0; i < CMAX + 6; i++) begin
      @(negedge clk);
      countStall(4'b0010);
      if (i == 10) checkVal("satMid", int'(stall_cycles), expCnt);
    end
    #1;
    checkVal("satHold", int'(stall_cycles), CMAX);
    checkVal("satModel", int'(stall_cycles), expCnt);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core with forwarding. The forwarding unit covers EX-stage operands; this block covers the hazards forwarding cannot resolve: load-use, ID-stage branch/jr operand dependencies, and the multi-cycle mult/div unit (MDU). It drives PC/IF-ID write enables and bubble/flush controls, and keeps a saturating stall-cycle performance counter.

Parameters:
MDU_LATENCY, 32, cycles an MDU op occupies HI/LO after it leaves ID/EX (legal range 2..63)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
rs_inIFID  input  5  rs field of instruction in ID
rt_inIFID  input  5  rt field of instruction in ID
uses_rs_inIFID  input  1  ID instruction reads rs
uses_rt_inIFID  input  1  ID instruction reads rt
branch_inIFID  input  1  ID instruction is branch/jr/jalr (operands compared in ID)
mdu_use_inIFID  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
take_branch  input  1  ID has resolved a taken branch/jump
MemRead_inIDEX  input  1  EX instruction is a load
RegWrite_inIDEX  input  1  EX instruction writes a register
rd_Or_rt_inIDEX  input  5  EX destination register
MemRead_inEXMEM  input  1  MEM instruction is a load
rd_Or_rt_inEXMEM  input  5  MEM destination register
mdu_start_inIDEX  input  1  EX instruction starts a mult/div
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register enable
IDEXFlush  output  1  insert bubble into ID/EX
IFIDFlush  output  1  squash the IF/ID instruction
mdu_busy  output  1  MDU occupied
stall_cycles  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Match(r) = r != 0 and r equals a used ID source (rs with uses_rs_inIFID, rt with uses_rt_inIFID).
- load_use: MemRead_inIDEX and Match(rd_Or_rt_inIDEX).
- br_ex: branch_inIFID and RegWrite_inIDEX and Match(rd_Or_rt_inIDEX); covers ALU result not yet ready (1 stall) and load (2 stalls via load_mem on the next cycle).
- load_mem: branch_inIFID and MemRead_inEXMEM and Match(rd_Or_rt_inEXMEM).
- mdu_hold: mdu_use_inIFID and mdu_busy.
- stall = load_use | br_ex | load_mem | mdu_hold. All combinational, same cycle.
- stall=1: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0; take_branch is ignored (operands not valid).
- stall=0 and take_branch=1: PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush=1 (no delay slot).
- Otherwise: PCWrite=1, IFIDWrite=1, both flushes 0.
- MDU FSM, states IDLE and BUSY, with a 6-bit down-counter cnt:
  - IDLE -> BUSY when mdu_start_inIDEX; cnt loads MDU_LATENCY-1.
  - In BUSY, cnt decrements each cycle; BUSY -> IDLE on the cycle cnt==1 (decrement to 0).
  - mdu_busy = (state==BUSY), registered. The op is busy for exactly MDU_LATENCY-1 cycles after the start cycle.
  - mdu_start_inIDEX while in BUSY cannot occur, because mdu_hold blocks it in ID. If asserted anyway, it is ignored and flagged in simulation only.
- stall_cycles increments on each clock with stall=1 and saturates at all-ones, with no wrap.
- Reset (async assert, any time, including mid-MDU-op): state=IDLE, cnt=0, mdu_busy=0, stall_cycles=0. Outputs then follow the combinational rules with mdu_busy=0; with idle inputs: PCWrite=1, IFIDWrite=1, flushes 0.
- Reset deassertion is synchronised externally. The first active edge after release behaves as a normal cycle.

Decomposition:
- Shared package/header: stall-cause encodings (NONE, LOAD_USE, BR_EX, LOAD_MEM, MDU) and the MDU_LATENCY default.
- One natural sub-module: mdu_busy_timer (IDLE/BUSY FSM plus counter). Hazard decode and the perf counter stay in the top.

Test Plan:
- lw $2 in EX (MemRead_inIDEX=1, rd_Or_rt_inIDEX=2), ID add uses rs=2 -> one cycle with PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle no stall; stall_cycles=1.
- lw $5 in EX, ID beq rs=5 -> stall for 2 consecutive cycles (br_ex, then load_mem); take_branch=1 during the stall leaves IFIDFlush=0. Third cycle with take_branch=1 -> IFIDFlush=1.
- ID uses rs=0 and EX load writes $0 -> no stall. RegWrite_inIDEX=0 with a branch match -> no stall.
- MDU_LATENCY=4: mdu_start_inIDEX pulse -> mdu_busy high for 3 cycles. ID mfhi stalls exactly those cycles, then issues.
- Assert rst_n=0 mid-MDU op (cnt=2) -> mdu_busy=0 and stall_cycles=0 immediately (async); after release, ID mflo issues without stall.
- Force stall=1 for 2^CNT_W+5 cycles -> stall_cycles holds at all-ones, no wrap.
